// File: rtl/sched_pkg.sv
// Shared definitions for the per-packet decision-phase scheduler.
package sched_pkg;

  localparam int unsigned SEL_WIDTH  = 4;
  localparam int unsigned NUM_PHASES = 9;

  // Phase indices double as the memory mux select values.
  typedef enum logic [SEL_WIDTH-1:0] {
    PH_LEARN_COSTS         = 4'd0,
    PH_AM_I_SINK           = 4'd1,
    PH_AM_I_FORWARDING     = 4'd2,
    PH_FIX_SINK_LIST       = 4'd3,
    PH_NEIGHBOR_SINK_OTHER = 4'd4,
    PH_FIND_MY_BEST        = 4'd5,
    PH_BETTER_NEIGHBORS    = 4'd6,
    PH_WINNER_POLICY       = 4'd7,
    PH_SELECT_ACTION       = 4'd8
  } phase_id_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_WAIT,
    ST_FINISH,
    ST_ABORT,
    ST_ERROR
  } sched_state_e;

  // A round is in progress in every state except IDLE and ERROR.
  function automatic logic state_is_busy(sched_state_e s);
    return (s == ST_LAUNCH) || (s == ST_WAIT) || (s == ST_FINISH) || (s == ST_ABORT);
  endfunction

endpackage

// File: rtl/phase_timeout_counter.sv
// Per-phase watchdog: counts WAIT cycles of the active phase.
module phase_timeout_counter #(
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic clr_i,
  input  logic inc_i,
  output logic tc_o
);
  localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  // Clear has priority over increment.
  always_comb begin
    cnt_d = cnt_q;
    if (clr_i) begin
      cnt_d = '0;
    end else if (inc_i) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  // Counter register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  // Flags the cycle whose increment makes the count reach TIMEOUT_CYCLES-1.
  assign tc_o = (cnt_q == CNT_W'(TIMEOUT_CYCLES - 2));

endmodule

// File: rtl/phase_scheduler.sv
// Sequences the decision phases, launching each with a start pulse and
// granting the shared memory port to the active phase.
module phase_scheduler #(
  parameter int unsigned NUM_PHASES     = sched_pkg::NUM_PHASES,
  parameter int unsigned SEL_WIDTH      = sched_pkg::SEL_WIDTH,
  parameter int unsigned TIMEOUT_CYCLES = 4096
) (
  input  logic                  clock,
  input  logic                  nrst,
  input  logic                  en,
  input  logic                  start,
  input  logic [NUM_PHASES-1:0] phase_done,
  input  logic [NUM_PHASES-1:0] phase_abort,
  output logic [NUM_PHASES-1:0] phase_start,
  output logic [SEL_WIDTH-1:0]  addr_select,
  output logic [SEL_WIDTH-1:0]  wr_select,
  output logic                  mem_grant,
  output logic                  busy,
  output logic                  round_done,
  output logic                  round_aborted,
  output logic [SEL_WIDTH-1:0]  abort_phase,
  output logic                  timeout_err,
  output logic [15:0]           round_count
);
  import sched_pkg::*;

  localparam logic [SEL_WIDTH-1:0] LAST_IDX = SEL_WIDTH'(NUM_PHASES - 1);

  sched_state_e          state_q;
  logic [SEL_WIDTH-1:0]  idx_q;
  logic [SEL_WIDTH-1:0]  abort_phase_q;
  logic                  timeout_err_q;
  logic [15:0]           round_count_q;

  logic                  cur_done;
  logic                  cur_abort;
  logic [NUM_PHASES-1:0] idx_onehot;
  logic                  tmo_clr;
  logic                  tmo_inc;
  logic                  tmo_tc;

  // Pick out the done/abort pair of the active phase; other phases are ignored.
  always_comb begin
    cur_done   = 1'b0;
    cur_abort  = 1'b0;
    idx_onehot = '0;
    for (int unsigned i = 0; i < NUM_PHASES; i++) begin
      if (idx_q == SEL_WIDTH'(i)) begin
        cur_done      = phase_done[i];
        cur_abort     = phase_abort[i];
        idx_onehot[i] = 1'b1;
      end
    end
  end

  // Watchdog control: restart on launch, count WAIT cycles without done.
  always_comb begin
    tmo_clr = en && (state_q == ST_LAUNCH);
    tmo_inc = en && (state_q == ST_WAIT) && !cur_done;
  end

  phase_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk_i (clock),
    .rst_ni(nrst),
    .clr_i (tmo_clr),
    .inc_i (tmo_inc),
    .tc_o  (tmo_tc)
  );

  // Round sequencer; everything freezes while en is low.
  always_ff @(posedge clock or negedge nrst) begin
    if (!nrst) begin
      state_q       <= ST_IDLE;
      idx_q         <= '0;
      abort_phase_q <= '0;
      timeout_err_q <= 1'b0;
      round_count_q <= '0;
    end else if (en) begin
      case (state_q)
        ST_IDLE, ST_ERROR: begin
          if (start) begin
            state_q       <= ST_LAUNCH;
            idx_q         <= '0;
            abort_phase_q <= '0;
            timeout_err_q <= 1'b0;
          end
        end
        ST_LAUNCH: begin
          state_q <= ST_WAIT;
        end
        ST_WAIT: begin
          if (cur_done) begin
            if (cur_abort) begin
              state_q       <= ST_ABORT;
              abort_phase_q <= idx_q;
              round_count_q <= round_count_q + 16'd1;
            end else if (idx_q == LAST_IDX) begin
              state_q       <= ST_FINISH;
              round_count_q <= round_count_q + 16'd1;
            end else begin
              state_q <= ST_LAUNCH;
              idx_q   <= idx_q + 1'b1;
            end
          end else if (tmo_tc) begin
            state_q       <= ST_ERROR;
            timeout_err_q <= 1'b1;
          end
        end
        ST_FINISH, ST_ABORT: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
        default: begin
          state_q <= ST_IDLE;
          idx_q   <= '0;
        end
      endcase
    end
  end

  // Output decode; pulses are masked while frozen and reappear once en returns.
  always_comb begin
    phase_start   = (en && (state_q == ST_LAUNCH)) ? idx_onehot : '0;
    round_done    = en && (state_q == ST_FINISH);
    round_aborted = en && (state_q == ST_ABORT);
    addr_select   = idx_q;
    wr_select     = idx_q;
    mem_grant     = (state_q == ST_LAUNCH) || (state_q == ST_WAIT);
    busy          = state_is_busy(state_q);
    abort_phase   = abort_phase_q;
    timeout_err   = timeout_err_q;
    round_count   = round_count_q;
  end

endmodule

// File: tb/tb_phase_scheduler.sv
// Scoreboard bench for phase_scheduler: expected launch/done/abort/timeout
// events are queued with their cycle stamps and matched as they appear.
module tb_phase_scheduler;

  localparam int NP   = 9;
  localparam int SW   = 4;
  localparam int TMO  = 16;
  localparam int K_LAUNCH = 0;
  localparam int K_DONE   = 1;
  localparam int K_ABORT  = 2;
  localparam int K_TMO    = 3;
  localparam int K_NONE   = 4;

  typedef struct {
    int kind;
    int idx;
    int cyc;
  } ev_t;

  logic          clock = 1'b0;
  logic          nrst;
  logic          en;
  logic          start;
  logic [NP-1:0] phase_done;
  logic [NP-1:0] phase_abort;
  logic [NP-1:0] phase_start;
  logic [SW-1:0] addr_select;
  logic [SW-1:0] wr_select;
  logic          mem_grant;
  logic          busy;
  logic          round_done;
  logic          round_aborted;
  logic [SW-1:0] abort_phase;
  logic          timeout_err;
  logic [15:0]   round_count;

  logic [NP-1:0] rsp_done;
  logic [NP-1:0] rsp_abort;
  logic [NP-1:0] man_done;
  int            cnt [NP];
  int            abort_ph;
  int            hang_ph;
  int            cyc = 0;
  int            n_cmp = 0;
  int            n_err = 0;
  logic          prev_tmo;
  ev_t           exp_q [$];

  assign phase_done  = rsp_done | man_done;
  assign phase_abort = rsp_abort;

  phase_scheduler #(
    .NUM_PHASES    (NP),
    .SEL_WIDTH     (SW),
    .TIMEOUT_CYCLES(TMO)
  ) dut (
    .clock        (clock),
    .nrst         (nrst),
    .en           (en),
    .start        (start),
    .phase_done   (phase_done),
    .phase_abort  (phase_abort),
    .phase_start  (phase_start),
    .addr_select  (addr_select),
    .wr_select    (wr_select),
    .mem_grant    (mem_grant),
    .busy         (busy),
    .round_done   (round_done),
    .round_aborted(round_aborted),
    .abort_phase  (abort_phase),
    .timeout_err  (timeout_err),
    .round_count  (round_count)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic push_ev(input int kind, input int idx, input int at);
    ev_t e;
    e.kind = kind;
    e.idx  = idx;
    e.cyc  = at;
    exp_q.push_back(e);
  endtask

  // Each phase occupies 1 LAUNCH + 3 WAIT cycles when answered 3 cycles after its start.
  task automatic push_round(input int n0, input int first, input int last,
                            input int end_kind, input int end_idx, input int end_dly);
    for (int i = first; i <= last; i++) push_ev(K_LAUNCH, i, n0 + 4 * (i - first));
    if (end_kind != K_NONE) push_ev(end_kind, end_idx, n0 + 4 * (last - first) + end_dly);
  endtask

  task automatic got_event(input int kind, input int idx);
    ev_t e;
    if (exp_q.size() == 0) begin
      check_eq("unexpected_event", kind, K_NONE);
    end else begin
      e = exp_q.pop_front();
      check_eq("ev_kind", kind, e.kind);
      check_eq("ev_idx", idx, e.idx);
      check_eq("ev_cycle", cyc, e.cyc);
    end
  endtask

  task automatic monitor();
    int idx;
    idx = -1;
    if (phase_start != '0) begin
      for (int i = 0; i < NP; i++) if (phase_start[i]) idx = i;
      check_eq("start_onehot", $countones(phase_start), 1);
      check_eq("grant_at_launch", mem_grant, 1);
      check_eq("addr_at_launch", addr_select, idx);
      got_event(K_LAUNCH, idx);
    end
    if (round_done) got_event(K_DONE, 0);
    if (round_aborted) got_event(K_ABORT, abort_phase);
    if (timeout_err && !prev_tmo) got_event(K_TMO, addr_select);
    prev_tmo = timeout_err;
    if (wr_select !== addr_select) check_eq("wr_eq_addr", wr_select, addr_select);
  endtask

  // Phase model: answers done exactly 3 cycles after its phase_start.
  task automatic responder();
    rsp_done  = '0;
    rsp_abort = '0;
    for (int i = 0; i < NP; i++) begin
      if (cnt[i] > 0) begin
        cnt[i]--;
        if (cnt[i] == 0) begin
          rsp_done[i] = 1'b1;
          if (i == abort_ph) rsp_abort[i] = 1'b1;
          cnt[i] = -1;
        end
      end
    end
    for (int i = 0; i < NP; i++) if (phase_start[i] && i != hang_ph) cnt[i] = 3;
  endtask

  task automatic cycle_step();
    @(negedge clock);
    monitor();
    responder();
  endtask

  task automatic step_until(input int target);
    while (cyc < target) cycle_step();
  endtask

  task automatic start_round(output int n0, input int last, input int ek,
                             input int eidx, input int edly);
    start = 1'b1;
    n0 = cyc + 1;
    push_round(n0, 0, last, ek, eidx, edly);
    cycle_step();
    start = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check_eq(tag, {phase_start, addr_select, wr_select, mem_grant, busy, round_done,
                   round_aborted, abort_phase, timeout_err}, 0);
    check_eq({tag, "_count"}, round_count, 0);
  endtask

  initial begin
    int n;
    int n2;
    nrst = 1'b0; en = 1'b1; start = 1'b0;
    rsp_done = '0; rsp_abort = '0; man_done = '0;
    abort_ph = -1; hang_ph = -1; prev_tmo = 1'b0;
    for (int i = 0; i < NP; i++) cnt[i] = -1;

    repeat (2) @(negedge clock);
    #1 check_all_zero("reset_outs");
    @(negedge clock);
    nrst = 1'b1;
    cycle_step();

    // Full round, done 3 cycles after each launch.
    start_round(n, 8, K_DONE, 0, 4);
    step_until(n + 37);
    check_eq("full_count", round_count, 1);
    check_eq("full_idle_busy", busy, 0);
    check_eq("full_pending", exp_q.size(), 0);

    // Abort on phase 1 together with its done.
    abort_ph = 1;
    start_round(n, 1, K_ABORT, 1, 4);
    step_until(n + 9);
    check_eq("abort_busy", busy, 0);
    check_eq("abort_addr", addr_select, 0);
    check_eq("abort_count", round_count, 2);
    check_eq("abort_pending", exp_q.size(), 0);
    abort_ph = -1;

    // Phase 4 hangs; timeout after 16 cycles.
    hang_ph = 4;
    start_round(n, 4, K_TMO, 4, TMO);
    check_eq("abort_phase_cleared", abort_phase, 0);
    step_until(n + 32);
    check_eq("tmo_err", timeout_err, 1);
    check_eq("tmo_grant", mem_grant, 0);
    check_eq("tmo_busy", busy, 0);
    check_eq("tmo_addr", addr_select, 4);
    hang_ph = -1;
    cycle_step();
    check_eq("tmo_sticky", timeout_err, 1);
    check_eq("tmo_count", round_count, 2);
    start_round(n, 8, K_DONE, 0, 4);
    check_eq("tmo_cleared", timeout_err, 0);
    step_until(n + 37);
    check_eq("restart_count", round_count, 3);
    check_eq("tmo_pending", exp_q.size(), 0);

    // en dropped for 5 cycles during WAIT of phase 2.
    hang_ph = 2;
    start_round(n, 2, K_NONE, 0, 0);
    step_until(n + 9);
    en = 1'b0;
    for (int k = 0; k < 5; k++) begin
      cycle_step();
      man_done[2] = (k == 1);
      check_eq("frozen_addr", addr_select, 2);
      check_eq("frozen_busy", busy, 1);
      check_eq("frozen_start", phase_start, 0);
    end
    en = 1'b1;
    man_done[2] = 1'b1;
    hang_ph = -1;
    n2 = cyc + 1;
    push_round(n2, 3, 8, K_DONE, 0, 4);
    cycle_step();
    man_done = '0;
    step_until(n2 + 25);
    check_eq("en_count", round_count, 4);
    check_eq("en_pending", exp_q.size(), 0);

    // Mid-round start, foreign done, and done during LAUNCH are all ignored.
    start_round(n, 8, K_DONE, 0, 4);
    step_until(n + 13);
    start = 1'b1;
    man_done[5] = 1'b1;
    cycle_step();
    start = 1'b0;
    man_done = '0;
    step_until(n + 16);
    man_done[4] = 1'b1;
    cycle_step();
    man_done = '0;
    step_until(n + 37);
    check_eq("ignore_count", round_count, 5);
    check_eq("ignore_pending", exp_q.size(), 0);

    // Asynchronous reset during phase 6.
    start_round(n, 6, K_NONE, 0, 0);
    step_until(n + 25);
    #2 nrst = 1'b0;
    #1 check_all_zero("async_rst");
    for (int i = 0; i < NP; i++) cnt[i] = -1;
    cycle_step();
    check_all_zero("rst_held");
    nrst = 1'b1;
    check_eq("rst_pending", exp_q.size(), 0);
    cycle_step();
    start_round(n, 8, K_DONE, 0, 4);
    step_until(n + 37);
    check_eq("post_rst_count", round_count, 1);
    check_eq("final_pending", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
